// File: rtl/alu_writeback_pc_if.sv
// Bus between the ALU/decode stage and the writeback/PC stage.
// alu_out keeps the ALU's bit ordering (index 0 is the MSB).
interface alu_writeback_pc_if #(
  parameter int WIDTH    = 32,
  parameter int PC_WIDTH = 32
);
  logic                valid_in;
  logic                stall;
  logic                instr_is_a;
  logic [WIDTH-1:0]    imm;
  logic [0:WIDTH-1]    alu_out;
  logic                zr;
  logic                ng;
  logic [2:0]          dest;
  logic [2:0]          jump;
  logic [WIDTH-1:0]    a_reg;
  logic [WIDTH-1:0]    d_reg;
  logic [PC_WIDTH-1:0] pc;
  logic                mem_we;
  logic [WIDTH-1:0]    mem_addr;
  logic [WIDTH-1:0]    mem_wdata;
  logic                zr_q;
  logic                ng_q;
  logic                taken;

  modport master (
    output valid_in, stall, instr_is_a, imm, alu_out, zr, ng, dest, jump,
    input  a_reg, d_reg, pc, mem_we, mem_addr, mem_wdata, zr_q, ng_q, taken
  );

  modport slave (
    input  valid_in, stall, instr_is_a, imm, alu_out, zr, ng, dest, jump,
    output a_reg, d_reg, pc, mem_we, mem_addr, mem_wdata, zr_q, ng_q, taken
  );
endinterface

// File: rtl/alu_writeback_pc.sv
// Post-ALU stage: A/D register writeback, data-memory write strobe,
// jump-condition evaluation and program counter.
module alu_writeback_pc #(
  parameter int                    WIDTH    = 32,
  parameter int                    PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input logic clk,
  input logic reset,
  alu_writeback_pc_if.slave bus
);
  logic [WIDTH-1:0]    a_q, d_q, addr_q, wdata_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                we_q, zr_q, ng_q, taken_q;
  logic [WIDTH-1:0]    res;
  logic                cond;
  logic                exec;

  assign res  = bus.alu_out;
  assign exec = bus.valid_in && !bus.stall;
  assign cond = (bus.jump[0] & bus.ng) |
                (bus.jump[1] & bus.zr) |
                (bus.jump[2] & ~bus.ng & ~bus.zr);

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      d_q     <= '0;
      pc_q    <= RESET_PC;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
      taken_q <= 1'b0;
    end else if (!exec) begin
      we_q    <= 1'b0;
      taken_q <= 1'b0;
    end else if (bus.instr_is_a) begin
      a_q     <= bus.imm;
      pc_q    <= pc_q + 1'b1;
      we_q    <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      // Jump target and memory address both use A as it was before this edge.
      if (bus.dest[0]) a_q <= res;
      if (bus.dest[1]) d_q <= res;
      we_q <= bus.dest[2];
      if (bus.dest[2]) begin
        addr_q  <= a_q;
        wdata_q <= res;
      end
      zr_q    <= bus.zr;
      ng_q    <= bus.ng;
      taken_q <= cond;
      pc_q    <= cond ? PC_WIDTH'(a_q) : pc_q + 1'b1;
    end
  end

  assign bus.a_reg     = a_q;
  assign bus.d_reg     = d_q;
  assign bus.pc        = pc_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.zr_q      = zr_q;
  assign bus.ng_q      = ng_q;
  assign bus.taken     = taken_q;
endmodule

// File: tb/tb_alu_writeback_pc.sv
// Directed vector bench for alu_writeback_pc: table of hand-computed
// per-cycle expectations plus reset sequences.
module tb_alu_writeback_pc;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  alu_writeback_pc_if #(.WIDTH(32), .PC_WIDTH(32)) bus ();

  alu_writeback_pc #(.WIDTH(32), .PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, stall, isa;
    logic [31:0] imm, alu;
    logic        zr, ng;
    logic [2:0]  dest, jump;
    logic [31:0] e_a, e_d, e_pc;
    logic        e_we;
    logic [31:0] e_addr, e_wd;
    logic        e_zq, e_nq, e_tk;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic v, logic s, logic isa, logic [31:0] imm,
                              logic [31:0] alu, logic zr, logic ng,
                              logic [2:0] dest, logic [2:0] jump,
                              logic [31:0] ea, logic [31:0] ed, logic [31:0] epc,
                              logic ewe, logic [31:0] eaddr, logic [31:0] ewd,
                              logic ezq, logic enq, logic etk);
    vec_t r;
    r.valid = v; r.stall = s; r.isa = isa; r.imm = imm; r.alu = alu;
    r.zr = zr; r.ng = ng; r.dest = dest; r.jump = jump;
    r.e_a = ea; r.e_d = ed; r.e_pc = epc; r.e_we = ewe;
    r.e_addr = eaddr; r.e_wd = ewd; r.e_zq = ezq; r.e_nq = enq; r.e_tk = etk;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [31:0] ea, logic [31:0] ed, logic [31:0] epc,
                         logic ewe, logic [31:0] eaddr, logic [31:0] ewd,
                         logic ezq, logic enq, logic etk);
    chk({tag, ".a_reg"},     bus.a_reg,     ea);
    chk({tag, ".d_reg"},     bus.d_reg,     ed);
    chk({tag, ".pc"},        bus.pc,        epc);
    chk({tag, ".mem_we"},    32'(bus.mem_we), 32'(ewe));
    chk({tag, ".mem_addr"},  bus.mem_addr,  eaddr);
    chk({tag, ".mem_wdata"}, bus.mem_wdata, ewd);
    chk({tag, ".zr_q"},      32'(bus.zr_q), 32'(ezq));
    chk({tag, ".ng_q"},      32'(bus.ng_q), 32'(enq));
    chk({tag, ".taken"},     32'(bus.taken), 32'(etk));
  endtask

  task automatic drive(vec_t v);
    bus.valid_in   = v.valid;
    bus.stall      = v.stall;
    bus.instr_is_a = v.isa;
    bus.imm        = v.imm;
    bus.alu_out    = v.alu;
    bus.zr         = v.zr;
    bus.ng         = v.ng;
    bus.dest       = v.dest;
    bus.jump       = v.jump;
  endtask

  initial begin
    //            v  s  isa imm           alu           zr ng dest    jump    a             d             pc            we addr   wdata  zq nq tk
    vecs[0]  = mk(1, 0, 1, 32'h0001F800, 32'h0,        0, 0, 3'b000, 3'b000, 32'h0001F800, 32'h0,        32'h1,        0, 32'h0,  32'h0,  0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 32'h0,        32'h0003F000, 0, 0, 3'b010, 3'b000, 32'h0001F800, 32'h0003F000, 32'h2,        0, 32'h0,  32'h0,  0, 0, 0);
    vecs[2]  = mk(1, 0, 1, 32'h10,       32'h0,        0, 0, 3'b000, 3'b000, 32'h10,       32'h0003F000, 32'h3,        0, 32'h0,  32'h0,  0, 0, 0);
    vecs[3]  = mk(1, 0, 0, 32'h0,        32'h55,       0, 0, 3'b101, 3'b000, 32'h55,       32'h0003F000, 32'h4,        1, 32'h10, 32'h55, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 32'h0,        32'h77,       1, 1, 3'b111, 3'b111, 32'h55,       32'h0003F000, 32'h4,        0, 32'h10, 32'h55, 0, 0, 0);
    vecs[5]  = mk(1, 0, 1, 32'h40,       32'h0,        0, 0, 3'b111, 3'b111, 32'h40,       32'h0003F000, 32'h5,        0, 32'h10, 32'h55, 0, 0, 0);
    vecs[6]  = mk(1, 0, 0, 32'h0,        32'h0,        1, 0, 3'b000, 3'b010, 32'h40,       32'h0003F000, 32'h40,       0, 32'h10, 32'h55, 1, 0, 1);
    vecs[7]  = mk(1, 0, 0, 32'h0,        32'h1,        0, 0, 3'b000, 3'b011, 32'h40,       32'h0003F000, 32'h41,       0, 32'h10, 32'h55, 0, 0, 0);
    vecs[8]  = mk(1, 0, 0, 32'h0,        32'h80000000, 0, 1, 3'b000, 3'b001, 32'h40,       32'h0003F000, 32'h40,       0, 32'h10, 32'h55, 0, 1, 1);
    vecs[9]  = mk(1, 0, 0, 32'h0,        32'h5,        0, 0, 3'b000, 3'b100, 32'h40,       32'h0003F000, 32'h40,       0, 32'h10, 32'h55, 0, 0, 1);
    vecs[10] = mk(1, 0, 1, 32'h20,       32'h0,        0, 0, 3'b000, 3'b000, 32'h20,       32'h0003F000, 32'h41,       0, 32'h10, 32'h55, 0, 0, 0);
    vecs[11] = mk(1, 0, 0, 32'h0,        32'h99,       0, 0, 3'b001, 3'b111, 32'h99,       32'h0003F000, 32'h20,       0, 32'h10, 32'h55, 0, 0, 1);
    vecs[12] = mk(1, 1, 0, 32'h0,        32'hDEAD,     1, 1, 3'b111, 3'b111, 32'h99,       32'h0003F000, 32'h20,       0, 32'h10, 32'h55, 0, 0, 0);
    vecs[13] = mk(1, 1, 1, 32'hBEEF,     32'h0,        0, 0, 3'b000, 3'b000, 32'h99,       32'h0003F000, 32'h20,       0, 32'h10, 32'h55, 0, 0, 0);
    vecs[14] = mk(1, 1, 0, 32'h0,        32'h1234,     0, 1, 3'b110, 3'b001, 32'h99,       32'h0003F000, 32'h20,       0, 32'h10, 32'h55, 0, 0, 0);
    vecs[15] = mk(1, 0, 1, 32'hFFFFFFFF, 32'h0,        0, 0, 3'b000, 3'b000, 32'hFFFFFFFF, 32'h0003F000, 32'h21,       0, 32'h10, 32'h55, 0, 0, 0);
    vecs[16] = mk(1, 0, 0, 32'h0,        32'h3,        0, 0, 3'b000, 3'b111, 32'hFFFFFFFF, 32'h0003F000, 32'hFFFFFFFF, 0, 32'h10, 32'h55, 0, 0, 1);
    vecs[17] = mk(1, 0, 0, 32'h0,        32'h3,        0, 0, 3'b000, 3'b000, 32'hFFFFFFFF, 32'h0003F000, 32'h0,        0, 32'h10, 32'h55, 0, 0, 0);

    // Reset held two cycles while stall and valid_in are both asserted.
    reset = 1'b1;
    drive(vecs[3]);
    bus.stall = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0);

    reset = 1'b0;
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), vecs[i].e_a, vecs[i].e_d, vecs[i].e_pc,
              vecs[i].e_we, vecs[i].e_addr, vecs[i].e_wd,
              vecs[i].e_zq, vecs[i].e_nq, vecs[i].e_tk);
    end

    // Flags and strobes set, then reset during a stall must still clear everything.
    drive(mk(1, 0, 0, 32'h0, 32'hAA, 1, 1, 3'b111, 3'b010, 0,0,0,0,0,0,0,0,0));
    @(posedge clk);
    #1;
    chk_all("pre_rst", 32'hAA, 32'hAA, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'hAA, 1, 1, 1);
    bus.stall = 1'b1;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    chk_all("rst_stall", 32'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0);

    // First valid instruction after reset release executes immediately.
    reset = 1'b0;
    drive(vecs[0]);
    @(posedge clk);
    #1;
    chk_all("post_rst", 32'h0001F800, 32'h0, 32'h1, 0, 32'h0, 32'h0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
